// File: rtl/beat_interval_detector_if.sv
// rtl/beat_interval_detector_if.sv - sample stream and beat/interval outputs of beat_interval_detector
interface beat_interval_detector_if #(
    parameter int WIDTH = 6,
    parameter int DW    = 8
);
    logic             en;
    logic [DW-1:0]    sample;
    logic             sample_valid;
    logic [DW-1:0]    threshold;
    logic [WIDTH-1:0] interval_count;
    logic             interval_valid;
    logic             beat_pulse;

    modport master (
        output en, sample, sample_valid, threshold,
        input  interval_count, interval_valid, beat_pulse
    );

    modport slave (
        input  en, sample, sample_valid, threshold,
        output interval_count, interval_valid, beat_pulse
    );
endinterface

// File: rtl/beat_interval_detector.sv
// rtl/beat_interval_detector.sv - threshold beat detector with hysteresis/refractory and interval counter
// Optional adaptive threshold (75% of last peak) built when BEAT_INTERVAL_ADAPTIVE_THR_EN is defined.
module beat_interval_detector #(
    parameter int WIDTH   = 6,
    parameter int DW      = 8,
    parameter int REFRACT = 5,
    parameter int HYST    = 8
) (
    input logic clk,
    input logic rst_n,
    beat_interval_detector_if.slave bus
);
    localparam logic [WIDTH-1:0] MAXC = '1;
    localparam int RW = (REFRACT > 1) ? $clog2(REFRACT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BELOW,
        S_REFR,
        S_ABOVE
    } state_t;

    state_t           state_q, state_d, cur_st;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             seen_q, seen_d;
    logic [RW-1:0]    refr_q, refr_d;
    logic [WIDTH-1:0] icount_q, icount_d;
    logic             ivalid_q, ivalid_d;
    logic             beat_q, beat_d;
    logic             beat_hit;
    logic [DW-1:0]    eff_thr;
    logic [DW-1:0]    rearm_lvl;

`ifdef BEAT_INTERVAL_ADAPTIVE_THR_EN
    logic [DW-1:0] pk_q, pk_d;
    logic [DW-1:0] last_pk_q, last_pk_d;
    logic [DW-1:0] pk75;

    assign pk75    = (last_pk_q >> 1) + (last_pk_q >> 2);
    assign eff_thr = (bus.threshold > pk75) ? bus.threshold : pk75;
`else
    assign eff_thr = bus.threshold;
`endif

    // A threshold below HYST floors the re-arm level at 0, which never re-arms.
    assign rearm_lvl = (eff_thr < DW'(HYST)) ? '0 : eff_thr - DW'(HYST);

    // IDLE is transparent: a sample arriving with en in the same cycle is judged as BELOW.
    assign cur_st = (state_q == S_IDLE) ? S_BELOW : state_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        seen_d   = seen_q;
        refr_d   = refr_q;
        icount_d = icount_q;
        ivalid_d = 1'b0;
        beat_d   = 1'b0;
        beat_hit = 1'b0;
`ifdef BEAT_INTERVAL_ADAPTIVE_THR_EN
        pk_d      = pk_q;
        last_pk_d = last_pk_q;
`endif
        if (!bus.en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            seen_d  = 1'b0;
            refr_d  = '0;
`ifdef BEAT_INTERVAL_ADAPTIVE_THR_EN
            pk_d      = '0;
            last_pk_d = '0;
`endif
        end else begin
            state_d = cur_st;
            if (bus.sample_valid) begin
                case (cur_st)
                    S_BELOW: beat_hit = (bus.sample >= eff_thr);
                    S_REFR: begin
`ifdef BEAT_INTERVAL_ADAPTIVE_THR_EN
                        if (bus.sample > pk_q) pk_d = bus.sample;
`endif
                        if (refr_q == '0) state_d = S_ABOVE;
                        else              refr_d  = refr_q - 1'b1;
                    end
                    S_ABOVE: begin
`ifdef BEAT_INTERVAL_ADAPTIVE_THR_EN
                        if (bus.sample > pk_q) pk_d = bus.sample;
`endif
                        if (bus.sample < rearm_lvl) begin
                            state_d = S_BELOW;
`ifdef BEAT_INTERVAL_ADAPTIVE_THR_EN
                            last_pk_d = pk_q;
                            pk_d      = '0;
`endif
                        end
                    end
                    default: state_d = S_BELOW;
                endcase

                if (beat_hit) begin
                    beat_d = 1'b1;
                    if (seen_q && cnt_q != MAXC) begin
                        icount_d = cnt_q + 1'b1;
                        ivalid_d = 1'b1;
                    end
                    cnt_d  = '0;
                    seen_d = 1'b1;
                    if (REFRACT == 0) begin
                        state_d = S_ABOVE;
                    end else begin
                        state_d = S_REFR;
                        refr_d  = RW'(REFRACT - 1);
                    end
                end else begin
                    cnt_d = (cnt_q == MAXC) ? MAXC : cnt_q + 1'b1;
`ifdef BEAT_INTERVAL_ADAPTIVE_THR_EN
                    // A stale peak must not keep the threshold raised once the rhythm is lost.
                    if (cnt_d == MAXC) last_pk_d = '0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            seen_q   <= 1'b0;
            refr_q   <= '0;
            icount_q <= '0;
            ivalid_q <= 1'b0;
            beat_q   <= 1'b0;
`ifdef BEAT_INTERVAL_ADAPTIVE_THR_EN
            pk_q      <= '0;
            last_pk_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
            refr_q   <= refr_d;
            icount_q <= icount_d;
            ivalid_q <= ivalid_d;
            beat_q   <= beat_d;
`ifdef BEAT_INTERVAL_ADAPTIVE_THR_EN
            pk_q      <= pk_d;
            last_pk_q <= last_pk_d;
`endif
        end
    end

    assign bus.interval_count = icount_q;
    assign bus.interval_valid = ivalid_q;
    assign bus.beat_pulse     = beat_q;
endmodule

// File: tb/tb_beat_interval_detector.sv
// tb/tb_beat_interval_detector.sv - directed spec scenarios plus randomized sessions against a tick-level model
module tb_beat_interval_detector;
    localparam int WIDTH   = 6;
    localparam int DW      = 8;
    localparam int REFRACT = 5;
    localparam int HYST    = 8;
    localparam int MAXC    = (1 << WIDTH) - 1;

    logic clk;
    logic rst_n;

    beat_interval_detector_if #(.WIDTH(WIDTH), .DW(DW)) bus ();

    beat_interval_detector #(
        .WIDTH(WIDTH), .DW(DW), .REFRACT(REFRACT), .HYST(HYST)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: ticks since enable, time of last accepted beat, re-arm flag.
    int m_k, m_last, m_count, m_thr;
    bit m_have, m_armed;
    bit pending_en;
    int n_beats, n_ivals, last_iv;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_k = 0; m_last = 0; m_have = 0; m_armed = 1;
        n_beats = 0; n_ivals = 0; last_iv = -1;
    endtask

    task automatic observe();
        if (bus.beat_pulse) n_beats++;
        if (bus.interval_valid) begin
            n_ivals++;
            last_iv = int'(bus.interval_count);
        end
    endtask

    task automatic tick(input int s, input int gap);
        bit exp_beat, exp_iv;
        int rearm, d;
        exp_beat = 0; exp_iv = 0;
        rearm = (m_thr < HYST) ? 0 : m_thr - HYST;
        @(negedge clk);
        if (pending_en) begin
            bus.en = 1'b1;
            pending_en = 0;
        end
        bus.sample = s[7:0];
        bus.sample_valid = 1'b1;
        d = m_k - m_last;
        if (!(m_have && d <= REFRACT)) begin
            if (!m_armed) begin
                if (s < rearm) m_armed = 1;
            end else if (s >= m_thr) begin
                exp_beat = 1;
                if (m_have && d <= MAXC) begin
                    exp_iv = 1;
                    m_count = d;
                end
                m_have = 1; m_last = m_k; m_armed = 0;
            end
        end
        m_k++;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        check("beat_pulse", int'(bus.beat_pulse), int'(exp_beat));
        check("interval_valid", int'(bus.interval_valid), int'(exp_iv));
        check("interval_count", int'(bus.interval_count), m_count);
        observe();
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            check("beat_idle", int'(bus.beat_pulse), 0);
            check("ival_idle", int'(bus.interval_valid), 0);
        end
    endtask

    // Drop en for two cycles, load a new threshold, and re-enable (or defer en to the next tick).
    task automatic restart(input int thr, input bit same_cycle);
        @(negedge clk);
        bus.en = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check("beat_off", int'(bus.beat_pulse), 0);
            check("ival_off", int'(bus.interval_valid), 0);
            check("icount_hold", int'(bus.interval_count), m_count);
        end
        bus.threshold = thr[7:0];
        m_thr = thr;
        model_clear();
        if (same_cycle) pending_en = 1;
        else begin
            @(negedge clk);
            bus.en = 1'b1;
        end
    endtask

    int s, thr, hp, r;

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.sample = '0;
        bus.sample_valid = 1'b0;
        bus.threshold = 8'd128;
        pending_en = 0;
        m_count = 0;
        m_thr = 128;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_icount", int'(bus.interval_count), 0);
        check("rst_ivalid", int'(bus.interval_valid), 0);
        check("rst_beat", int'(bus.beat_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Beats every 25 ticks, 3-tick wide peaks.
        restart(128, 0);
        for (int t = 0; t <= 52; t++) tick((t % 25 < 3) ? 200 : 20, t % 2);
        check("s1_beats", n_beats, 3);
        check("s1_ivals", n_ivals, 2);
        check("s1_last_iv", last_iv, 25);

        // Second crossing falls inside the refractory window.
        restart(128, 0);
        for (int t = 0; t <= 31; t++) tick((t == 0 || t == 3 || t == 30) ? 200 : 20, 0);
        check("s2_beats", n_beats, 2);
        check("s2_ivals", n_ivals, 1);
        check("s2_last_iv", last_iv, 30);

        // Gap of 70 saturates the counter; the next beat only restarts measurement.
        restart(128, 0);
        for (int t = 0; t <= 101; t++) tick((t == 0 || t == 70 || t == 100) ? 200 : 20, 0);
        check("s3_beats", n_beats, 3);
        check("s3_ivals", n_ivals, 1);
        check("s3_last_iv", last_iv, 30);

        // Oscillation inside the hysteresis band must not re-trigger.
        restart(128, 0);
        tick(200, 0);
        for (int t = 0; t < 30; t++) tick(126 + (t % 7), 0);
        check("s4_beats_band", n_beats, 1);
        tick(119, 0);
        tick(130, 0);
        check("s4_beats", n_beats, 2);

        // en drop after a beat; re-enable coincident with a sample.
        restart(128, 0);
        for (int t = 0; t < 10; t++) tick((t == 0) ? 200 : 20, 0);
        restart(128, 1);
        for (int t = 0; t <= 30; t++) tick((t == 5 || t == 30) ? 200 : 20, 0);
        check("s5_beats", n_beats, 2);
        check("s5_ivals", n_ivals, 1);
        check("s5_last_iv", last_iv, 25);

        // Randomized sessions with varying beat density (sparse ones exercise saturation).
        for (int sess = 0; sess < 6; sess++) begin
            thr = $urandom_range(40, 220);
            hp = (sess % 3 == 0) ? 2 : ((sess % 3 == 1) ? 25 : 50);
            restart(thr, sess[0]);
            for (int t = 0; t < 150; t++) begin
                r = $urandom_range(0, 99);
                if (r < hp) s = $urandom_range(thr, 255);
                else if (r < hp + 15) s = $urandom_range(thr - HYST, thr - 1);
                else s = $urandom_range(0, thr - HYST - 1);
                tick(s, $urandom_range(0, 2));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
